mcs8_sysctl: RTL and testbench

System-controller responder for the MCS8 core: sits on the CPU's multiplexed 8-bit bus and decodes the T-state/cycle sequence the CPU state machine emits. Demultiplexes the 14-bit address and cycle type, drives memory and I/O strobes, returns read data, generates READY with programmable wait states, and optionally supplies the interrupt-acknowledge instruction.

---
 rtl/mcs8_pkg.sv | 37 +++
 rtl/mcs8_sysctl_wait_cnt.sv | 23 ++
 rtl/mcs8_sysctl.sv | 176 +++++++++++++++++
 tb/tb_mcs8_sysctl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mcs8_pkg.sv
// Shared encodings for the MCS8 system controller: CPU T-state codes,
// bus cycle types, controller FSM states and the RST opcode template.
package mcs8_pkg;

   typedef enum logic [2:0] {
      TS_WAIT = 3'b000,
      TS_T3   = 3'b001,
      TS_T1   = 3'b010,
      TS_STOP = 3'b011,
      TS_T2   = 3'b100,
      TS_T5   = 3'b101,
      TS_T1I  = 3'b110,
      TS_T4   = 3'b111
   } tstate_t;

   typedef enum logic [1:0] {
      CYC_PCI = 2'b00,
      CYC_PCR = 2'b01,
      CYC_PCC = 2'b10,
      CYC_PCW = 2'b11
   } cyc_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_L,
      S_ADDR_H,
      S_XFER,
      S_DONE
   } fsm_t;

   localparam logic [2:0] RST_OP_LO = 3'b101;

   function automatic logic [7:0] rst_opcode(input logic [2:0] vec);
      return {2'b00, vec, RST_OP_LO};
   endfunction

endpackage

// File: rtl/mcs8_sysctl_wait_cnt.sv
// Wait-state counter: loads a 4-bit count, decrements every clock down to
// zero; zero_o doubles as the READY indication.
module sysctl_wait_cnt (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   output logic       zero_o
);

   logic [3:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)               cnt_q <= '0;
      else if (clr_i)          cnt_q <= '0;
      else if (load_i)         cnt_q <= load_val_i;
      else if (cnt_q != '0)    cnt_q <= cnt_q - 4'd1;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mcs8_sysctl.sv
// MCS8 bus system controller: decodes T-state sequence, drives memory/I/O
// strobes and READY. Define SYSCTL_INT_ACK_EN to answer T1I fetches with RST n.
module mcs8_sysctl
   import mcs8_pkg::*;
#(
   parameter int unsigned WAIT_N    = 0,
   parameter int unsigned IO_IN_MAX = 7
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        SYNC_I,
   input  logic [2:0]  STATE_I,
   input  logic [7:0]  D_I,
   output logic [7:0]  D_O,
   output logic        D_OE_O,
   output logic        READY_O,
   output logic [13:0] MEM_A_O,
   output logic        MEM_RD_O,
   output logic        MEM_WR_O,
   input  logic [7:0]  MEM_DI_I,
   output logic [7:0]  MEM_DO_O,
   output logic [4:0]  IO_ADDR_O,
   output logic        IO_RD_O,
   output logic        IO_WR_O,
   input  logic [7:0]  IO_DI_I,
   output logic [7:0]  IO_DO_O,
   input  logic [2:0]  INT_VEC_I
);

`ifdef SYSCTL_INT_ACK_EN
   localparam bit INT_ACK = 1'b1;
`else
   localparam bit INT_ACK = 1'b0;
`endif
   localparam logic [5:0] IN_MAX = 6'(IO_IN_MAX);
   localparam logic [3:0] WAITS  = 4'(WAIT_N);

   fsm_t        state_q;
   cyc_t        typ_q;
   logic [7:0]  addr_lo_q, d_o_q, mem_do_q, io_do_q;
   logic [13:0] mem_a_q;
   logic [4:0]  io_addr_q;
   logic        int_ack_q, valid_q, rd_cyc_q, out_cyc_q, started_q;
   logic        mem_rd_q, io_rd_q, mem_wr_q, io_wr_q, mem_wr_pend_q, io_wr_pend_q;

   tstate_t ts;
   logic    restart, abort, ready, cnt_load, cnt_clr, ack_fetch;

   assign ts        = tstate_t'(STATE_I);
   assign restart   = SYNC_I && (ts == TS_T1 || ts == TS_T1I);
   assign ack_fetch = INT_ACK && int_ack_q && (typ_q == CYC_PCI);

   always_comb begin
      abort = 1'b0;
      if (SYNC_I && !restart) begin
         case (state_q)
            S_ADDR_L: abort = (ts != TS_T2);
            S_ADDR_H: abort = !(ts == TS_T2 || ts == TS_WAIT);
            S_XFER:   abort = (ts != TS_T3);
            S_DONE:   abort = !(ts == TS_T4 || ts == TS_T5);
            default:  abort = 1'b0;
         endcase
      end
   end

   // Counter loads on the first ADDR_H clock so READY drops the edge after T2.
   assign cnt_clr  = abort || restart;
   assign cnt_load = (state_q == S_ADDR_H) && !started_q && !cnt_clr;

   sysctl_wait_cnt u_wait (
      .clk_i      (CLK_I),
      .rst_i      (RST_I),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i (WAITS),
      .zero_o     (ready)
   );

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q       <= S_IDLE;
         typ_q         <= CYC_PCI;
         addr_lo_q     <= '0;
         d_o_q         <= '0;
         mem_do_q      <= '0;
         io_do_q       <= '0;
         mem_a_q       <= '0;
         io_addr_q     <= '0;
         int_ack_q     <= 1'b0;
         valid_q       <= 1'b0;
         rd_cyc_q      <= 1'b0;
         out_cyc_q     <= 1'b0;
         started_q     <= 1'b0;
         mem_rd_q      <= 1'b0;
         io_rd_q       <= 1'b0;
         mem_wr_q      <= 1'b0;
         io_wr_q       <= 1'b0;
         mem_wr_pend_q <= 1'b0;
         io_wr_pend_q  <= 1'b0;
      end else begin
         mem_wr_q      <= mem_wr_pend_q;
         io_wr_q       <= io_wr_pend_q;
         mem_wr_pend_q <= 1'b0;
         io_wr_pend_q  <= 1'b0;
         if (restart) begin
            state_q   <= S_ADDR_L;
            addr_lo_q <= D_I;
            int_ack_q <= (ts == TS_T1I);
            valid_q   <= 1'b0;
            started_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            io_rd_q   <= 1'b0;
         end else if (abort) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            io_rd_q  <= 1'b0;
            mem_wr_q <= 1'b0;
            io_wr_q  <= 1'b0;
         end else begin
            case (state_q)
               S_ADDR_L: if (SYNC_I && ts == TS_T2) begin
                  typ_q     <= cyc_t'(D_I[7:6]);
                  mem_a_q   <= {D_I[5:0], addr_lo_q};
                  if (cyc_t'(D_I[7:6]) == CYC_PCC) io_addr_q <= D_I[5:1];
                  rd_cyc_q  <= (D_I[7] == 1'b0) ||
                               (D_I[7:6] == 2'b10 && {1'b0, D_I[5:1]} <= IN_MAX);
                  out_cyc_q <= (D_I[7:6] == 2'b10) && ({1'b0, D_I[5:1]} > IN_MAX);
                  valid_q   <= 1'b1;
                  started_q <= 1'b0;
                  state_q   <= S_ADDR_H;
               end
               S_ADDR_H: if (!started_q) begin
                  started_q <= 1'b1;
                  mem_rd_q  <= (typ_q == CYC_PCI || typ_q == CYC_PCR) && !ack_fetch;
                  io_rd_q   <= (typ_q == CYC_PCC) && rd_cyc_q;
               end else if (ready) begin
                  if (typ_q == CYC_PCC) begin
                     if (rd_cyc_q) d_o_q <= IO_DI_I;
                  end else if (typ_q != CYC_PCW) begin
                     d_o_q <= ack_fetch ? rst_opcode(INT_VEC_I) : MEM_DI_I;
                  end
                  mem_rd_q <= 1'b0;
                  io_rd_q  <= 1'b0;
                  state_q  <= S_XFER;
               end
               S_XFER: if (SYNC_I && ts == TS_T3) begin
                  if (typ_q == CYC_PCW) begin
                     mem_do_q      <= D_I;
                     mem_wr_pend_q <= 1'b1;
                  end
                  if (out_cyc_q) begin
                     io_do_q      <= addr_lo_q;
                     io_wr_pend_q <= 1'b1;
                  end
                  state_q <= S_DONE;
               end
               default: ;
            endcase
         end
      end
   end

   assign D_O       = d_o_q;
   assign D_OE_O    = valid_q && rd_cyc_q && (ts == TS_T3);
   assign READY_O   = ready;
   assign MEM_A_O   = mem_a_q;
   assign MEM_RD_O  = mem_rd_q;
   assign MEM_WR_O  = mem_wr_q;
   assign MEM_DO_O  = mem_do_q;
   assign IO_ADDR_O = io_addr_q;
   assign IO_RD_O   = io_rd_q;
   assign IO_WR_O   = io_wr_q;
   assign IO_DO_O   = io_do_q;

endmodule

// File: tb/tb_mcs8_sysctl.sv
// Directed bench for mcs8_sysctl: a zero-wait and a three-wait instance
// share one stimulus bus; each scenario task checks its own expectations.
module tb_mcs8_sysctl;

   localparam logic [2:0] T1 = 3'b010, T1I = 3'b110, T2 = 3'b100, TW = 3'b000;
   localparam logic [2:0] T3 = 3'b001, T4 = 3'b111, T5 = 3'b101;

   logic       clk, rst, sync;
   logic [2:0] st, vec;
   logic [7:0] d, mem_di, io_di;

   logic [7:0]  d_o0, mdo0, iodo0, d_o3, mdo3, iodo3;
   logic        oe0, rdy0, mrd0, mwr0, iord0, iowr0;
   logic        oe3, rdy3, mrd3, mwr3, iord3, iowr3;
   logic [13:0] a0, a3;
   logic [4:0]  ioa0, ioa3;

   int n_cmp = 0;
   int n_err = 0;

   mcs8_sysctl #(.WAIT_N(0), .IO_IN_MAX(7)) u0 (
      .CLK_I(clk), .RST_I(rst), .SYNC_I(sync), .STATE_I(st), .D_I(d),
      .D_O(d_o0), .D_OE_O(oe0), .READY_O(rdy0), .MEM_A_O(a0),
      .MEM_RD_O(mrd0), .MEM_WR_O(mwr0), .MEM_DI_I(mem_di), .MEM_DO_O(mdo0),
      .IO_ADDR_O(ioa0), .IO_RD_O(iord0), .IO_WR_O(iowr0), .IO_DI_I(io_di),
      .IO_DO_O(iodo0), .INT_VEC_I(vec));

   mcs8_sysctl #(.WAIT_N(3), .IO_IN_MAX(7)) u3 (
      .CLK_I(clk), .RST_I(rst), .SYNC_I(sync), .STATE_I(st), .D_I(d),
      .D_O(d_o3), .D_OE_O(oe3), .READY_O(rdy3), .MEM_A_O(a3),
      .MEM_RD_O(mrd3), .MEM_WR_O(mwr3), .MEM_DI_I(mem_di), .MEM_DO_O(mdo3),
      .IO_ADDR_O(ioa3), .IO_RD_O(iord3), .IO_WR_O(iowr3), .IO_DI_I(io_di),
      .IO_DO_O(iodo3), .INT_VEC_I(vec));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input logic s, input logic [2:0] t, input logic [7:0] dv);
      sync = s; st = t; d = dv;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; sync = 1'b0; st = TW; d = 8'h00;
      mem_di = 8'h00; io_di = 8'h00; vec = 3'd0;
      #12;
      n_cmp++; if (d_o0 !== 8'h00) begin n_err++; $display("FAIL rst_d_o: got %h want 00", d_o0); end
      n_cmp++; if (oe0 !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", oe0); end
      n_cmp++; if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b%b want 11", rdy0, rdy3); end
      n_cmp++; if (a0 !== 14'h0000) begin n_err++; $display("FAIL rst_addr: got %h want 0000", a0); end
      n_cmp++; if ({mrd0, mwr0, iord0, iowr0} !== 4'b0000) begin n_err++; $display("FAIL rst_strobes: got %b want 0000", {mrd0, mwr0, iord0, iowr0}); end
      n_cmp++; if ({mdo0, iodo0, 3'b000, ioa0} !== 24'h0) begin n_err++; $display("FAIL rst_data: got %h want 000000", {mdo0, iodo0, 3'b000, ioa0}); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_fetch;
      mem_di = 8'hC0;
      step(1, T1, 8'h34);
      n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL fetch_rdy_t1: got %b want 1", rdy0); end
      step(1, T2, 8'h12);
      n_cmp++; if (a0 !== 14'h1234) begin n_err++; $display("FAIL fetch_addr: got %h want 1234", a0); end
      n_cmp++; if (mrd0 !== 1'b0) begin n_err++; $display("FAIL fetch_rd_t2: got %b want 0", mrd0); end
      step(0, T2, 8'h00);
      n_cmp++; if (mrd0 !== 1'b1 || rdy0 !== 1'b1) begin n_err++; $display("FAIL fetch_rd_on: got rd=%b rdy=%b want 1 1", mrd0, rdy0); end
      step(0, T2, 8'h00);
      n_cmp++; if (mrd0 !== 1'b0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL fetch_rd_off: got rd=%b rdy=%b want 0 1", mrd0, rdy0); end
      n_cmp++; if (d_o0 !== 8'hC0) begin n_err++; $display("FAIL fetch_data: got %h want c0", d_o0); end
      step(1, T3, 8'h00);
      n_cmp++; if (oe0 !== 1'b1) begin n_err++; $display("FAIL fetch_oe_t3: got %b want 1", oe0); end
      step(1, T4, 8'h00);
      n_cmp++; if (oe0 !== 1'b0) begin n_err++; $display("FAIL fetch_oe_t4: got %b want 0", oe0); end
      step(1, T5, 8'h00);
   endtask

   task automatic test_wait_read;
      int lows = 0, rds = 0, first_low = -1;
      mem_di = 8'h77;
      step(1, T1, 8'h66);
      step(1, T2, 8'h45);
      n_cmp++; if (a3 !== 14'h0566) begin n_err++; $display("FAIL wait_addr: got %h want 0566", a3); end
      n_cmp++; if (rdy3 !== 1'b1) begin n_err++; $display("FAIL wait_rdy_t2: got %b want 1", rdy3); end
      for (int i = 0; i < 8; i++) begin
         step(0, TW, 8'h00);
         if (rdy3 === 1'b0) begin lows++; if (first_low < 0) first_low = i; end
         if (mrd3 === 1'b1) rds++;
      end
      n_cmp++; if (lows != 3 || first_low != 0) begin n_err++; $display("FAIL wait_ready_low: got %0d clocks from %0d want 3 from 0", lows, first_low); end
      n_cmp++; if (rds != 4) begin n_err++; $display("FAIL wait_rd_len: got %0d want 4", rds); end
      n_cmp++; if (d_o3 !== 8'h77) begin n_err++; $display("FAIL wait_data: got %h want 77", d_o3); end
      step(1, T3, 8'h00);
      n_cmp++; if (oe3 !== 1'b1) begin n_err++; $display("FAIL wait_oe: got %b want 1", oe3); end
      step(1, T4, 8'h00);
   endtask

   task automatic test_write;
      int pulses = 0;
      step(1, T1, 8'h20);
      step(1, T2, 8'hC1);
      n_cmp++; if (a0 !== 14'h0120) begin n_err++; $display("FAIL wr_addr: got %h want 0120", a0); end
      step(0, T2, 8'h00);
      step(0, T2, 8'h00);
      n_cmp++; if (mrd0 !== 1'b0) begin n_err++; $display("FAIL wr_no_rd: got %b want 0", mrd0); end
      step(1, T3, 8'hAA);
      n_cmp++; if (oe0 !== 1'b0 || mwr0 !== 1'b0) begin n_err++; $display("FAIL wr_t3: got oe=%b wr=%b want 0 0", oe0, mwr0); end
      for (int i = 0; i < 3; i++) begin
         step(0, T3, 8'h00);
         if (mwr0 === 1'b1) pulses++;
         if (i == 0) begin
            n_cmp++; if (mwr0 !== 1'b1 || mdo0 !== 8'hAA) begin n_err++; $display("FAIL wr_pulse: got wr=%b do=%h want 1 aa", mwr0, mdo0); end
         end
      end
      n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL wr_len: got %0d want 1", pulses); end
      step(1, T4, 8'h00);
   endtask

   task automatic test_io_out;
      int pulses = 0;
      step(1, T1, 8'h5A);
      step(1, T2, 8'h92);
      n_cmp++; if (ioa0 !== 5'd9) begin n_err++; $display("FAIL out_port: got %0d want 9", ioa0); end
      step(0, T2, 8'h00);
      n_cmp++; if (iord0 !== 1'b0) begin n_err++; $display("FAIL out_no_rd: got %b want 0", iord0); end
      step(0, T2, 8'h00);
      step(1, T3, 8'h00);
      n_cmp++; if (iowr0 !== 1'b0) begin n_err++; $display("FAIL out_t3: got %b want 0", iowr0); end
      for (int i = 0; i < 3; i++) begin
         step(0, T3, 8'h00);
         if (iowr0 === 1'b1) pulses++;
         if (i == 0) begin
            n_cmp++; if (iowr0 !== 1'b1 || iodo0 !== 8'h5A) begin n_err++; $display("FAIL out_pulse: got wr=%b do=%h want 1 5a", iowr0, iodo0); end
         end
      end
      n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL out_len: got %0d want 1", pulses); end
      step(1, T4, 8'h00);
   endtask

   task automatic test_io_in;
      io_di = 8'h3C;
      step(1, T1, 8'h00);
      step(1, T2, 8'h86);
      n_cmp++; if (ioa0 !== 5'd3) begin n_err++; $display("FAIL in_port: got %0d want 3", ioa0); end
      step(0, T2, 8'h00);
      n_cmp++; if (iord0 !== 1'b1 || mrd0 !== 1'b0) begin n_err++; $display("FAIL in_rd_on: got io=%b mem=%b want 1 0", iord0, mrd0); end
      step(0, T2, 8'h00);
      n_cmp++; if (iord0 !== 1'b0 || d_o0 !== 8'h3C) begin n_err++; $display("FAIL in_data: got rd=%b d=%h want 0 3c", iord0, d_o0); end
      step(1, T3, 8'h00);
      n_cmp++; if (oe0 !== 1'b1) begin n_err++; $display("FAIL in_oe: got %b want 1", oe0); end
      step(1, T4, 8'h00);
   endtask

   task automatic test_int_ack;
`ifdef SYSCTL_INT_ACK_EN
      logic       exp_rd = 1'b0;
      logic [7:0] exp_d  = 8'h2D;
`else
      logic       exp_rd = 1'b1;
      logic [7:0] exp_d  = 8'hC0;
`endif
      vec = 3'd5; mem_di = 8'hC0;
      step(1, T1I, 8'h78);
      step(1, T2, 8'h3F);
      n_cmp++; if (a0 !== 14'h3F78) begin n_err++; $display("FAIL ack_addr: got %h want 3f78", a0); end
      step(0, T2, 8'h00);
      n_cmp++; if (mrd0 !== exp_rd) begin n_err++; $display("FAIL ack_rd: got %b want %b", mrd0, exp_rd); end
      step(0, T2, 8'h00);
      n_cmp++; if (d_o0 !== exp_d) begin n_err++; $display("FAIL ack_data: got %h want %h", d_o0, exp_d); end
      step(1, T3, 8'h00);
      n_cmp++; if (oe0 !== 1'b1) begin n_err++; $display("FAIL ack_oe: got %b want 1", oe0); end
      step(1, T4, 8'h00);
   endtask

   task automatic test_abort;
      step(1, T1, 8'h55);
      step(1, T3, 8'h00);
      n_cmp++; if (oe0 !== 1'b0) begin n_err++; $display("FAIL abort_oe: got %b want 0", oe0); end
      step(1, T2, 8'h33);
      n_cmp++; if (a0 !== 14'h3F78) begin n_err++; $display("FAIL abort_addr_held: got %h want 3f78", a0); end
      step(0, T2, 8'h00);
      n_cmp++; if (mrd0 !== 1'b0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL abort_idle: got rd=%b rdy=%b want 0 1", mrd0, rdy0); end
   endtask

   task automatic test_reset_mid;
      int rds = 0;
      mem_di = 8'h99;
      step(1, T1, 8'h22);
      step(1, T2, 8'h48);
      step(0, TW, 8'h00);
      n_cmp++; if (rdy3 !== 1'b0 || mrd3 !== 1'b1) begin n_err++; $display("FAIL mid_pre: got rdy=%b rd=%b want 0 1", rdy3, mrd3); end
      @(negedge clk); rst = 1'b1; #1;
      n_cmp++; if (rdy3 !== 1'b1 || mrd3 !== 1'b0) begin n_err++; $display("FAIL mid_rst: got rdy=%b rd=%b want 1 0", rdy3, mrd3); end
      n_cmp++; if (a3 !== 14'h0000 || d_o3 !== 8'h00) begin n_err++; $display("FAIL mid_rst_regs: got a=%h d=%h want 0000 00", a3, d_o3); end
      @(negedge clk); rst = 1'b0;
      step(1, T1, 8'h11);
      step(1, T2, 8'h47);
      n_cmp++; if (a3 !== 14'h0711) begin n_err++; $display("FAIL mid_addr: got %h want 0711", a3); end
      for (int i = 0; i < 6; i++) begin
         step(0, TW, 8'h00);
         if (mrd3 === 1'b1) rds++;
      end
      n_cmp++; if (rds != 4 || d_o3 !== 8'h99) begin n_err++; $display("FAIL mid_read: got rd=%0d d=%h want 4 99", rds, d_o3); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_wait_read();
      test_write();
      test_io_out();
      test_io_in();
      test_int_ack();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
